tsv_link_rx: RTL and testbench
==============================

// Module: tsv_link_rx
// PURPOSE
//  Receive end of the inter-tier TSV link. The transmitter on the source tier serializes an
//  inter-tier word over LANES TSVs. This block deserializes it on the destination tier,
//  checks parity and buffers words in a DEPTH-entry FIFO for local logic (valid/ready).
//  Returns tsv_rdy across the TSV so the transmitter only starts a frame when a slot is free.
// PARAMETERS
//  WIDTH  16  parallel word width; must be a multiple of LANES
//  LANES  2   TSV data lanes per beat; BEATS = WIDTH/LANES (>=2)
//  DEPTH  2   output FIFO entries (>=1)
// PORTS
//  clk1      in   1      link clock, shared by both tiers
//  rst       in   1      synchronous active-high reset
//  tsv_frm   in   1      frame start; high on beat 0 of a frame only
//  tsv_dat   in   LANES  beat data; beat k carries word bits [k*LANES +: LANES] (LSB first)
//  tsv_par   in   1      even parity of the whole word; sampled on last beat only
//  tsv_rdy   out  1      to TX: a frame may start next cycle
//  rx_data   out  WIDTH  head-of-FIFO word
//  rx_valid  out  1      rx_data valid
//  rx_ready  in   1      consumer accepts; pop when rx_valid & rx_ready
//  err_cnt   out  8      saturating count of parity + framing errors
//  ovf_err   out  1      sticky: frame started while tsv_rdy was low
// BEHAVIOUR
//  Reset: all outputs 0 (tsv_rdy=0, rx_valid=0, rx_data=0, err_cnt=0, ovf_err=0).
//   FSM -> IDLE, FIFO empty, beat counter 0. tsv_rdy rises the first cycle after rst drops.
//  FSM IDLE:
//   - tsv_frm=1: capture beat 0, cnt=1, go to RECV.
//   - tsv_frm=0: stay; tsv_dat is ignored.
//  FSM RECV:
//   - Capture beat cnt, cnt++.
//   - Framing error (tsv_frm=1 mid-frame): err_cnt++, discard the partial word, treat this beat
//     as beat 0 of a new frame (cnt=1, stay in RECV). Reservation is retained.
//   - Last beat (cnt==BEATS-1, tsv_frm=0): assemble word W.
//     If ^W == tsv_par, push W; else drop W and err_cnt++. Either case: go to IDLE.
//   - Back-to-back: tsv_frm=1 in the cycle after the last beat is a legal new frame.
//  Latency: word visible on rx_data/rx_valid the cycle after its last beat (registered).
//  FIFO:
//   - Push and pop in the same cycle are both performed; count is unchanged.
//   - Pop when empty is ignored. rx_data holds its value when not popping.
//   - With rx_valid high, rx_data is stable until accepted.
//  Reservation:
//   - A frame reserves one slot from beat 0 until its push or drop.
//   - tsv_rdy (registered) = (fifo_count + reserved) < DEPTH, evaluated using next-cycle state.
//  Overflow:
//   - Beat-0 tsv_frm while tsv_rdy was low the previous cycle: entire frame ignored
//     (FSM stays IDLE; skips BEATS cycles via a drop counter), ovf_err=1 until rst.
//   - Does not increment err_cnt.
//  err_cnt saturates at 8'hFF. Parity and framing errors in the same cycle are impossible
//   (framing is checked first).
//  Reset mid-frame: partial word discarded, FIFO flushed, no push.
// TESTING (WIDTH=16, LANES=2, DEPTH=2; BEATS=8)
//  1 Send 0xA5C3, par=0, rx_ready=1
//    -> rx_valid 1 cycle after beat 7, rx_data=16'hA5C3, err_cnt=0.
//  2 Send 0x0001 with par=0 (wrong)
//    -> no rx_valid, err_cnt=1; a following 0x0001 with par=1 is delivered.
//  3 rx_ready=0, send 2 frames back-to-back
//    -> tsv_rdy=0 from beat 0 of frame 2; after one pop, tsv_rdy=1 next cycle;
//       data 1st,2nd in order.
//  4 tsv_frm re-asserted on beat 4, then a full 0x1234 frame
//    -> err_cnt=1, only 0x1234 delivered.
//  5 Frame while tsv_rdy=0
//    -> ovf_err=1, FIFO contents unchanged, next legal frame received normally.
//  6 Assert rst on beat 5, then send 0xBEEF
//    -> outputs all 0 during rst, only 0xBEEF delivered; force 300 errors -> err_cnt=8'hFF.

Source files
------------

// File: rtl/tsv_link_rx.sv
// Receive end of the inter-tier TSV link: deserializes LANES-wide beats into WIDTH-bit words,
// checks even parity and buffers good words in a DEPTH-entry valid/ready FIFO.
module tsv_link_rx #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             tsv_frm,
    input  logic [LANES-1:0] tsv_dat,
    input  logic             tsv_par,
    output logic             tsv_rdy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       err_cnt,
    output logic             ovf_err,
    output logic             fsm_state
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = $clog2(BEATS);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // Handshake: a word leaves the FIFO on a clock edge where rx_valid && rx_ready; rx_data
    // is held stable while rx_valid is high and not accepted.
    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [WIDTH-1:0] word_q, word_d, word_asm;
    logic [CW-1:0]    beat_idx;
    logic             beat_en, push, err_inc;
    logic             ovf_q, ovf_d;
    logic             rdy_q, rdy_d;
    logic [7:0]       err_q, err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]    count_q, count_d;
    logic             pop, do_push;

    // A frame restart (beat 0) always lands in slot 0, whatever the current beat count.
    assign beat_idx = (state_q == ST_IDLE || tsv_frm) ? '0 : cnt_q;

    always_comb begin
        word_asm = word_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_idx == CW'(k)) word_asm[k*LANES +: LANES] = tsv_dat;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        beat_en = 1'b0;
        push    = 1'b0;
        err_inc = 1'b0;
        if (drop_q != '0) begin
            drop_d = drop_q - CW'(1);
        end else if (state_q == ST_IDLE) begin
            if (tsv_frm) begin
                if (!rdy_q) begin
                    ovf_d  = 1'b1;
                    drop_d = LAST;
                end else begin
                    beat_en = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = ST_RECV;
                end
            end
        end else begin
            beat_en = 1'b1;
            if (tsv_frm) begin
                err_inc = 1'b1;
                cnt_d   = CW'(1);
            end else if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if ((^word_asm) == tsv_par) push = 1'b1;
                else                        err_inc = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        word_d = beat_en ? word_asm : word_q;
        err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_comb begin
        pop     = (count_q != '0) && rx_ready;
        do_push = push && ((count_q != NW'(DEPTH)) || pop);
        count_d = count_q + NW'(do_push) - NW'(pop);
        // A frame in RECV holds one slot until it is pushed or dropped.
        rdy_d   = (int'(count_d) + int'(state_d == ST_RECV)) < DEPTH;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drop_q   <= '0;
            word_q   <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
            err_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= word_asm;
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    assign tsv_rdy   = rdy_q;
    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign err_cnt   = err_q;
    assign ovf_err   = ovf_q;
    assign fsm_state = state_q;
endmodule

// File: tb/tb_tsv_link_rx.sv
// Bench for tsv_link_rx: vector table, hand-built corner sequences and a randomized phase
// checked against a word-level queue model of the link.
module tb_tsv_link_rx;
    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        tsv_frm = 1'b0;
    logic [1:0]  tsv_dat = '0;
    logic        tsv_par = 1'b0;
    logic        tsv_rdy;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  err_cnt;
    logic        ovf_err;
    logic        fsm_state;

    tsv_link_rx #(.WIDTH(16), .LANES(2), .DEPTH(2)) dut (
        .clk1(clk1), .rst(rst), .tsv_frm(tsv_frm), .tsv_dat(tsv_dat), .tsv_par(tsv_par),
        .tsv_rdy(tsv_rdy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err_cnt(err_cnt), .ovf_err(ovf_err), .fsm_state(fsm_state)
    );

    always #5 clk1 = ~clk1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_err = 0;
    logic [15:0] exp_q[$];
    bit          rand_ready = 1'b0;

    typedef struct {
        logic [15:0] word;
        logic        par;
        bit          deliver;
        int          err_after;
    } vec_t;
    vec_t vecs[7];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every accepted word must be the oldest expected one.
    always @(negedge clk1) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h, expected no word", rx_data);
            end else begin
                check("pop_data", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    always @(posedge clk1) begin
        if (rand_ready) begin
            #1;
            rx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        tsv_frm = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!tsv_rdy && t < 300) begin
            tick();
            t++;
        end
        if (!tsv_rdy) check("wait_rdy_timeout", 32'(tsv_rdy), 32'd1);
    endtask

    task automatic send_partial(input logic [15:0] w, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            tsv_frm = (k == 0);
            tsv_dat = w[k*2 +: 2];
            tsv_par = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic par, input bit wait_first,
                             input int chk_b0);
        if (wait_first) wait_rdy();
        for (int k = 0; k < 8; k++) begin
            tsv_frm = (k == 0);
            tsv_dat = w[k*2 +: 2];
            tsv_par = (k == 7) ? par : 1'($urandom_range(0, 1));
            tick();
            if (k == 0 && chk_b0 >= 0) check("rdy_after_beat0", 32'(tsv_rdy), 32'(chk_b0));
        end
        tsv_frm = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_tsv_rdy", 32'(tsv_rdy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0001, 1'b0, 1'b0, 1};
        vecs[1] = '{16'h0001, 1'b1, 1'b1, 1};
        vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 1};
        vecs[3] = '{16'h8000, 1'b0, 1'b0, 2};
        vecs[4] = '{16'h1234, 1'b1, 1'b1, 2};
        vecs[5] = '{16'h00FF, 1'b1, 1'b0, 3};
        vecs[6] = '{16'h0F0E, 1'b1, 1'b1, 3};

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check("rdy_after_reset", 32'(tsv_rdy), 32'd1);

        // Single good word, registered one-cycle latency.
        rx_ready = 1'b1;
        exp_q.push_back(16'hA5C3);
        send_word(16'hA5C3, 1'b0, 1'b1, -1);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'hA5C3);
        check("t1_err", 32'(err_cnt), 32'd0);
        idle(2);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].deliver) exp_q.push_back(vecs[i].word);
            send_word(vecs[i].word, vecs[i].par, 1'b1, -1);
            idle(2);
            check("vec_err_cnt", 32'(err_cnt), 32'(vecs[i].err_after));
        end
        exp_err = 3;
        check("vec_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames into a stalled consumer.
        rx_ready = 1'b0;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        send_word(16'h1111, 1'b0, 1'b1, -1);
        send_word(16'h2222, 1'b0, 1'b0, 0);
        check("t3_head", 32'(rx_data), 32'h1111);
        idle(3);
        check("t3_full_rdy", 32'(tsv_rdy), 32'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t3_rdy_after_pop", 32'(tsv_rdy), 32'd1);
        check("t3_second", 32'(rx_data), 32'h2222);
        rx_ready = 1'b1;
        idle(3);

        // Randomized traffic with well-behaved transmitter.
        rand_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            logic [15:0] w;
            logic        p;
            bit          good;
            w    = 16'($urandom);
            good = ($urandom_range(0, 9) != 0);
            p    = good ? ^w : ~^w;
            if (good) exp_q.push_back(w);
            else      exp_err++;
            if ($urandom_range(0, 9) == 0) begin
                wait_rdy();
                send_partial(16'($urandom), int'($urandom_range(1, 7)));
                exp_err++;
                send_word(w, p, 1'b0, -1);
            end else begin
                send_word(w, p, 1'b1, -1);
            end
            idle(int'($urandom_range(0, 3)));
        end
        rand_ready = 1'b0;
        tick();
        rx_ready = 1'b1;
        idle(10);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
        check("rand_no_ovf", 32'(ovf_err), 32'd0);

        // Framing error: restart on beat 4.
        exp_q.push_back(16'h1234);
        wait_rdy();
        send_partial(16'hAAAA, 4);
        send_word(16'h1234, 1'b1, 1'b0, -1);
        exp_err++;
        idle(3);
        check("t4_err_cnt", 32'(err_cnt), 32'(exp_err));
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Frame sent while tsv_rdy is low.
        rx_ready = 1'b0;
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        send_word(16'h3333, 1'b0, 1'b1, -1);
        send_word(16'h4444, 1'b0, 1'b1, -1);
        idle(1);
        check("t5_rdy_low", 32'(tsv_rdy), 32'd0);
        send_word(16'h5555, 1'b0, 1'b0, -1);
        idle(2);
        check("t5_ovf", 32'(ovf_err), 32'd1);
        check("t5_head", 32'(rx_data), 32'h3333);
        check("t5_valid", 32'(rx_valid), 32'd1);
        check("t5_err_cnt", 32'(err_cnt), 32'(exp_err));
        rx_ready = 1'b1;
        idle(4);
        exp_q.push_back(16'h6666);
        send_word(16'h6666, 1'b0, 1'b1, -1);
        idle(3);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame, then saturate the error counter.
        wait_rdy();
        send_partial(16'hDEAD, 5);
        tsv_frm = 1'b0;
        tsv_dat = 2'b11;
        rst = 1'b1;
        tick();
        check_reset_outputs();
        tick();
        check_reset_outputs();
        exp_q.delete();
        exp_err = 0;
        rst = 1'b0;
        tick();
        check("t6_rdy_after_reset", 32'(tsv_rdy), 32'd1);
        exp_q.push_back(16'hBEEF);
        send_word(16'hBEEF, 1'b1, 1'b1, -1);
        idle(3);
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_err_zero", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            send_word(16'h0001, 1'b0, 1'b1, -1);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        idle(3);
        check("t6_err_sat", 32'(err_cnt), 32'(exp_err));
        check("t6_no_words", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
